mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one bus access per load/store, stalls upstream until the
// access completes or times out, and drives register-file writeback.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_in,
    input  logic [3:0]  dst_addr_in,
    input  logic [15:0] alu_in,
    input  logic        Mem_re_in,
    input  logic        Mem_we_in,
    input  logic        Mem_sel_in,
    input  logic [15:0] d_addr_in,
    input  logic [15:0] wrt_data_in,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        mem_sel,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_we,
    output logic [3:0]  wb_dst_addr,
    output logic [15:0] wb_data,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_wr_q, mem_wr_d;
    logic          mem_sel_q, mem_sel_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic          wb_we_q, wb_we_d;
    logic [3:0]    wb_dst_q, wb_dst_d;
    logic [15:0]   wb_data_q, wb_data_d;
    logic          bus_err_q, bus_err_d;
    logic          stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_we_q     <= 1'b0;
            wb_dst_q    <= '0;
            wb_data_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_we_q     <= wb_we_d;
            wb_dst_q    <= wb_dst_d;
            wb_data_q   <= wb_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // wb_we and bus_err default low so each writeback/error is a single-cycle event.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_we_d     = 1'b0;
        wb_dst_d    = wb_dst_q;
        wb_data_d   = wb_data_q;
        bus_err_d   = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Mem_re_in || Mem_we_in) begin
                    stall_c     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = Mem_we_in;
                    mem_sel_d   = Mem_sel_in;
                    mem_addr_d  = d_addr_in;
                    mem_wdata_d = wrt_data_in;
                    tmo_cnt_d   = '0;
                    state_d     = BUSY;
                end else begin
                    wb_we_d   = we_in;
                    wb_dst_d  = dst_addr_in;
                    wb_data_d = alu_in;
                end
            end
            BUSY: begin
                // Ack takes priority over the terminal count.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!mem_wr_q) begin
                        wb_we_d   = we_in;
                        wb_dst_d  = dst_addr_in;
                        wb_data_d = mem_rdata;
                    end
                end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_c   = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Upstream must not be frozen while the stage is held in reset.
    assign stall       = stall_c & rst_n;
    assign mem_req     = mem_req_q;
    assign mem_wr      = mem_wr_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_we       = wb_we_q;
    assign wb_dst_addr = wb_dst_q;
    assign wb_data     = wb_data_q;
    assign bus_err     = bus_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of operations with a bus responder and a writeback scoreboard,
// plus hand-written reset, idle-ack and back-to-back sequences.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_in;
    logic [3:0]  dst_addr_in;
    logic [15:0] alu_in;
    logic        Mem_re_in, Mem_we_in, Mem_sel_in;
    logic [15:0] d_addr_in, wrt_data_in;
    logic        mem_req, mem_wr, mem_sel;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall, wb_we, bus_err;
    logic [3:0]  wb_dst_addr;
    logic [15:0] wb_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [15:0] alu;
        logic        re, wr, sel;
        logic [15:0] addr, wdata, rdata;
        int          ack_at;     // BUSY cycle carrying the ack, 0 = never
        int          exp_stall;
        logic        exp_err;
        logic        exp_wb;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] data;
    } wb_t;

    wb_t  sbq[$];
    vec_t tbl[8];

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .we_in(we_in), .dst_addr_in(dst_addr_in), .alu_in(alu_in),
        .Mem_re_in(Mem_re_in), .Mem_we_in(Mem_we_in), .Mem_sel_in(Mem_sel_in),
        .d_addr_in(d_addr_in), .wrt_data_in(wrt_data_in),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .wb_we(wb_we), .wb_dst_addr(wb_dst_addr), .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Every writeback pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_we === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got dst=%0h data=%0h want no writeback", wb_dst_addr, wb_data);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                chk("wb_dst", {28'h0, wb_dst_addr}, {28'h0, e.dst});
                chk("wb_data", {16'h0, wb_data}, {16'h0, e.data});
            end
        end
    end

    task automatic drive_idle();
        we_in = 0; dst_addr_in = 0; alu_in = 0;
        Mem_re_in = 0; Mem_we_in = 0; Mem_sel_in = 0;
        d_addr_in = 0; wrt_data_in = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic idle_cycle();
        drive_idle();
        @(posedge clk); #1;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_op(input vec_t v);
        int  busy = 0;
        int  sc = 0;
        int  first_busy = -1;
        bit  done = 0;
        bit  bus_checked = 0;
        we_in = v.we; dst_addr_in = v.dst; alu_in = v.alu;
        Mem_re_in = v.re; Mem_we_in = v.wr; Mem_sel_in = v.sel;
        d_addr_in = v.addr; wrt_data_in = v.wdata;
        if (v.exp_wb) sbq.push_back('{dst: v.dst, data: v.exp_data});
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) begin
                busy++;
                if (first_busy < 0) first_busy = c;
                mem_ack   = (busy == v.ack_at);
                mem_rdata = v.rdata;
            end else begin
                mem_ack = 0;
            end
            @(negedge clk);
            if (mem_req && !bus_checked) begin
                bus_checked = 1;
                chk("mem_wr", {31'h0, mem_wr}, {31'h0, v.wr});
                chk("mem_sel", {31'h0, mem_sel}, {31'h0, v.sel});
                chk("mem_addr", {16'h0, mem_addr}, {16'h0, v.addr});
                chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, v.wdata});
            end
            if (stall) sc++;
            else done = 1;
            @(posedge clk); #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL op_timeout: got stall still high after 40 cycles want completion");
        end
        mem_ack = 0;
        chk("stall_cycles", sc, v.exp_stall);
        chk("bus_err", {31'h0, bus_err}, {31'h0, v.exp_err});
        chk("mem_req_done", {31'h0, mem_req}, 32'h0);
        if (v.re || v.wr) chk("issue_latency", first_busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //        we dst  alu      re wr sel addr     wdata    rdata    ack stall err wb data
        tbl[0] = '{1, 4'd3,  16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0,  0, 1, 16'h1234};
        tbl[1] = '{1, 4'd5,  16'h0000, 1, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 3,  3,  0, 1, 16'hBEEF};
        tbl[2] = '{1, 4'd6,  16'h0000, 0, 1, 1, 16'h0100, 16'hA5A5, 16'h0000, 1,  1,  0, 0, 16'h0000};
        tbl[3] = '{1, 4'd7,  16'h0000, 1, 0, 0, 16'h0080, 16'h0000, 16'h0000, 0, 16,  1, 0, 16'h0000};
        tbl[4] = '{1, 4'd9,  16'h0000, 1, 0, 0, 16'h0090, 16'h0000, 16'h5A5A, 16, 16, 0, 1, 16'h5A5A};
        tbl[5] = '{1, 4'd10, 16'h0000, 1, 1, 0, 16'h0200, 16'h1111, 16'h2222, 2,  2,  0, 0, 16'h0000};
        tbl[6] = '{0, 4'd11, 16'h7777, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0,  0, 0, 16'h0000};
        tbl[7] = '{1, 4'd15, 16'h0000, 1, 0, 1, 16'hFFF0, 16'h0000, 16'hFFFF, 1,  1,  0, 1, 16'hFFFF};

        drive_idle();
        rst_n = 0;
        Mem_re_in = 1;
        #3;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_wb_we", {31'h0, wb_we}, 32'h0);
        chk("rst_wb_data", {16'h0, wb_data}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i]);
            idle_cycle();
            chk("bus_err_pulse", {31'h0, bus_err}, 32'h0);
        end

        // Ack while idle must be ignored.
        drive_idle();
        mem_ack = 1;
        mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        chk("idle_ack_req", {31'h0, mem_req}, 32'h0);
        chk("idle_ack_err", {31'h0, bus_err}, 32'h0);
        chk("idle_ack_stall", {31'h0, stall}, 32'h0);
        idle_cycle();

        // Back-to-back loads with no gap between them.
        v = tbl[1]; v.dst = 4'd1; v.rdata = 16'h0101; v.exp_data = 16'h0101; v.ack_at = 2; v.exp_stall = 2;
        run_op(v);
        v.dst = 4'd2; v.rdata = 16'h0202; v.exp_data = 16'h0202; v.ack_at = 1; v.exp_stall = 1;
        run_op(v);
        idle_cycle();

        // Reset in the middle of a load abandons it.
        we_in = 1; dst_addr_in = 4'd4; Mem_re_in = 1; d_addr_in = 16'h0044;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        chk("midrst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("midrst_wb_we", {31'h0, wb_we}, 32'h0);
        chk("midrst_bus_err", {31'h0, bus_err}, 32'h0);
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1;
        v = tbl[0]; v.dst = 4'd2; v.alu = 16'h0F0F; v.exp_data = 16'h0F0F;
        run_op(v);
        idle_cycle();
        idle_cycle();

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
